// File: rtl/ssd_scroll_ctrl.sv
// Four-digit seven-segment sequencer. It scans the digits through active-low
// selects and scrolls a MSG_LEN-character message one position per
// SCROLL_DIV frames, in either direction.
module ssd_scroll_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int SCROLL_DIV = 100,
  parameter int MSG_LEN    = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  output logic [3:0] char_idx,
  output logic [3:0] ssd_ctl,
  output logic       step_pulse
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_DIV - 1);
  localparam logic [3:0]    HEAD_LAST  = 4'(MSG_LEN - 1);
  localparam logic [4:0]    LEN5       = 5'(MSG_LEN);

  logic [SW-1:0] scanCnt_q, scanCnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [FW-1:0] frameCnt_q, frameCnt_d;
  logic [3:0]    head_q, head_d;
  logic          stepPulse_q, stepPulse_d;

  logic scanWrap;
  logic frameBoundary;
  logic stepNow;
  logic [4:0] rawIdx;
  logic [4:0] idxOnce;
  logic [4:0] idxTwice;

  assign scanWrap      = (scanCnt_q == SCAN_LAST);
  assign frameBoundary = scanWrap && (digit_q == 2'd3);
  assign stepNow       = frameBoundary && en && (frameCnt_q == FRAME_LAST);

  // Next-state logic: the scan always runs, and enabled frames are counted
  // until the head steps on the frame that completes a scroll period.
  always_comb begin
    scanCnt_d   = scanCnt_q + SW'(1);
    digit_d     = digit_q;
    frameCnt_d  = frameCnt_q;
    head_d      = head_q;
    stepPulse_d = stepNow;
    if (scanWrap) begin
      scanCnt_d = '0;
      digit_d   = digit_q + 2'd1;
    end
    if (frameBoundary && en) begin
      if (frameCnt_q == FRAME_LAST) begin
        frameCnt_d = '0;
        if (dir) begin
          head_d = (head_q == 4'd0) ? HEAD_LAST : head_q - 4'd1;
        end else begin
          head_d = (head_q == HEAD_LAST) ? 4'd0 : head_q + 4'd1;
        end
      end else begin
        frameCnt_d = frameCnt_q + FW'(1);
      end
    end
  end

  // State registers; a low rst_n at an edge discards any step in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scanCnt_q   <= '0;
      digit_q     <= 2'd0;
      frameCnt_q  <= '0;
      head_q      <= 4'd0;
      stepPulse_q <= 1'b0;
    end else begin
      scanCnt_q   <= scanCnt_d;
      digit_q     <= digit_d;
      frameCnt_q  <= frameCnt_d;
      head_q      <= head_d;
      stepPulse_q <= stepPulse_d;
    end
  end

  // Output decode from registers only. The raw index can reach MSG_LEN+2,
  // which for the shortest message needs two conditional subtractions.
  always_comb begin
    rawIdx   = {1'b0, head_q} + 5'd3 - {3'b000, digit_q};
    idxOnce  = (rawIdx >= LEN5) ? rawIdx - LEN5 : rawIdx;
    idxTwice = (idxOnce >= LEN5) ? idxOnce - LEN5 : idxOnce;
    char_idx = idxTwice[3:0];
    ssd_ctl  = ~(4'b0001 << digit_q);
  end

  assign step_pulse = stepPulse_q;

endmodule

// File: tb/tb_ssd_scroll_ctrl.sv
// Bench for ssd_scroll_ctrl: a tick-counting reference model checked every
// cycle, plus literal expectations at hand-picked points of each scenario.
`timescale 1ns/1ps
module tb_ssd_scroll_ctrl;

  localparam int SD = 2;
  localparam int SC = 2;
  localparam int ML = 6;
  localparam int FRAME = 4 * SD;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic [3:0] char_idx;
  logic [3:0] ssd_ctl;
  logic       step_pulse;

  int errors;
  int checks;
  int tick;
  bit checkEn;

  int mTick;
  int mHead;
  int mEnFrames;
  bit mPulse;

  logic [3:0] selTable [4];

  ssd_scroll_ctrl #(
    .SCAN_DIV(SD),
    .SCROLL_DIV(SC),
    .MSG_LEN(ML)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .dir(dir),
    .char_idx(char_idx),
    .ssd_ctl(ssd_ctl),
    .step_pulse(step_pulse)
  );

  // Free-running clock; edges at 5, 15, 25 ... and sampling on negedges
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: counts ticks since reset and enabled frames, and moves
  // the head arithmetically every SC enabled frames.
  always @(posedge clk) begin
    if (!rst_n) begin
      mTick     = 0;
      mHead     = 0;
      mEnFrames = 0;
      mPulse    = 1'b0;
    end else begin
      mPulse = 1'b0;
      if ((mTick % FRAME) == FRAME - 1 && en) begin
        mEnFrames = mEnFrames + 1;
        if ((mEnFrames % SC) == 0) begin
          mHead  = dir ? (mHead + ML - 1) % ML : (mHead + 1) % ML;
          mPulse = 1'b1;
        end
      end
      mTick = mTick + 1;
    end
  end

  // Every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    int digit;
    logic [3:0] expSel;
    logic [3:0] expChar;
    if (checkEn) begin
      digit   = (mTick / SD) % 4;
      expSel  = selTable[digit];
      expChar = 4'((mHead + 3 - digit) % ML);
      checks  = checks + 1;
      if (ssd_ctl !== expSel || char_idx !== expChar || step_pulse !== mPulse) begin
        errors = errors + 1;
        $display("[TB] FAIL model t=%0t: ssd=%b idx=%0d pulse=%b, expected ssd=%b idx=%0d pulse=%b",
                 $time, ssd_ctl, char_idx, step_pulse, expSel, expChar, mPulse);
      end
    end
  end

  // Drive inputs at a negedge, then let nCycles edges pass
  task automatic applyStimulus(input logic rstV, input logic enV, input logic dirV, input int nCycles);
    rst_n = rstV;
    en    = enV;
    dir   = dirV;
    repeat (nCycles) begin
      @(negedge clk);
      tick = tick + 1;
    end
  endtask

  // Compare DUT outputs against hand-computed literal values
  task automatic checkOutput(input string name, input logic [3:0] expSel,
                             input logic [3:0] expChar, input logic expPulse);
    checks = checks + 1;
    if (ssd_ctl !== expSel || char_idx !== expChar || step_pulse !== expPulse) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: ssd=%b idx=%0d pulse=%b, expected ssd=%b idx=%0d pulse=%b",
               name, ssd_ctl, char_idx, step_pulse, expSel, expChar, expPulse);
    end
  endtask

  // Reset for one edge, then release with the given enable and direction
  task automatic restart(input logic enV, input logic dirV);
    applyStimulus(1'b0, enV, dirV, 1);
    checkOutput("reset_pulse", 4'b1110, 4'd3, 1'b0);
    tick  = 0;
    rst_n = 1'b1;
  endtask

  // Advance (inputs held) until the tick count reaches target
  task automatic runTo(input int target);
    applyStimulus(rst_n, en, dir, target - tick);
  endtask

  logic [3:0] scanSel  [8];
  logic [3:0] scanChar [8];

  initial begin
    errors  = 0;
    checks  = 0;
    tick    = 0;
    checkEn = 1'b0;
    selTable[0] = 4'b1110;
    selTable[1] = 4'b1101;
    selTable[2] = 4'b1011;
    selTable[3] = 4'b0111;
    scanSel[0] = 4'b1110; scanChar[0] = 4'd3;
    scanSel[1] = 4'b1101; scanChar[1] = 4'd2;
    scanSel[2] = 4'b1101; scanChar[2] = 4'd2;
    scanSel[3] = 4'b1011; scanChar[3] = 4'd1;
    scanSel[4] = 4'b1011; scanChar[4] = 4'd1;
    scanSel[5] = 4'b0111; scanChar[5] = 4'd0;
    scanSel[6] = 4'b0111; scanChar[6] = 4'd0;
    scanSel[7] = 4'b1110; scanChar[7] = 4'd3;
    rst_n = 1'b0;
    en    = 1'b0;
    dir   = 1'b0;

    // Reset held for three edges
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_hold", 4'b1110, 4'd3, 1'b0);
    checkEn = 1'b1;

    // Scan with scroll disabled: one full frame, then check head stays put
    tick = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput($sformatf("scan_%0d", k + 1), scanSel[k], scanChar[k], 1'b0);
    end
    runTo(40);
    checkOutput("scan_frozen", 4'b1110, 4'd3, 1'b0);

    // Forward scroll from reset
    restart(1'b1, 1'b0);
    runTo(15);
    checkOutput("fwd_before_step", 4'b0111, 4'd0, 1'b0);
    runTo(16);
    checkOutput("fwd_step1", 4'b1110, 4'd4, 1'b1);
    runTo(17);
    checkOutput("fwd_pulse_drop", 4'b1110, 4'd4, 1'b0);
    runTo(22);
    checkOutput("fwd_digit3_head1", 4'b0111, 4'd1, 1'b0);
    runTo(80);
    checkOutput("fwd_head5_d0", 4'b1110, 4'd2, 1'b1);
    runTo(82);
    checkOutput("fwd_head5_d1", 4'b1101, 4'd1, 1'b0);
    runTo(84);
    checkOutput("fwd_head5_d2", 4'b1011, 4'd0, 1'b0);
    runTo(86);
    checkOutput("fwd_head5_d3", 4'b0111, 4'd5, 1'b0);
    runTo(96);
    checkOutput("fwd_wrap_head0", 4'b1110, 4'd3, 1'b1);

    // Reverse scroll wraps head 0 to MSG_LEN-1
    restart(1'b1, 1'b1);
    runTo(16);
    checkOutput("rev_step_d0", 4'b1110, 4'd2, 1'b1);
    runTo(22);
    checkOutput("rev_digit3", 4'b0111, 4'd5, 1'b0);

    // Enable hold: one enabled frame, three frozen frames, then one more
    restart(1'b1, 1'b0);
    runTo(8);
    applyStimulus(1'b1, 1'b0, 1'b0, 24);
    checkOutput("hold_frozen", 4'b1110, 4'd3, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 7);
    checkOutput("hold_no_early", 4'b0111, 4'd0, 1'b0);
    runTo(40);
    checkOutput("hold_step", 4'b1110, 4'd4, 1'b1);

    // Mid-operation reset at head=3, digit=2
    restart(1'b1, 1'b0);
    runTo(52);
    checkOutput("mid_before", 4'b1011, 4'd4, 1'b0);
    restart(1'b1, 1'b0);
    runTo(15);
    checkOutput("mid_no_early", 4'b0111, 4'd0, 1'b0);
    runTo(16);
    checkOutput("mid_step", 4'b1110, 4'd4, 1'b1);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
